spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- Sequencer that drives the SPI byte master to perform serial-flash READ transactions.
- Owns chip-select and issues the command byte plus a 24-bit address, then clocks out dummy bytes and streams received data bytes to the requester.
- Sits between the boot/ROM loader and the SPI byte master; the master handles the clock, MOSI and MISO, and this block handles framing.

Parameters:
- LEN_W, 16, width of the byte-count input.
- CS_SETUP_CLKS, 8, i_Clk cycles from CS_n low to the first byte.
- CS_HOLD_CLKS, 8, i_Clk cycles from the last byte received to CS_n high.
- CS_IDLE_CLKS, 16, minimum i_Clk cycles CS_n stays high before the next transaction.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  synchronous active-high reset
- i_Req  in  1  start pulse; sampled only in IDLE
- i_Addr  in  24  flash byte address
- i_Len  in  LEN_W  number of data bytes to read
- o_Busy  out  1  high from request acceptance until return to IDLE
- o_Done  out  1  one-cycle pulse when the transaction completes
- o_Data  out  8  received data byte
- o_Data_DV  out  1  one-cycle strobe with o_Data
- o_TX_Byte  out  8  byte to the master
- o_TX_DV  out  1  one-cycle pulse to the master
- i_TX_Ready  in  1  master ready
- i_RX_DV  in  1  master byte-received pulse
- i_RX_Byte  in  8  master received byte
- o_SPI_CS_n  out  1  flash chip select, active low

Behaviour:
- Interface: one clock, i_Clk. Reset is synchronous and active-high on i_Rst.
- Reset values: o_SPI_CS_n=1; o_Busy, o_Done, o_Data_DV, o_TX_DV = 0; o_Data, o_TX_Byte = 0x00; state IDLE; all counters 0.
- Reset mid-transaction: the same values apply at the next edge. CS_n releases immediately. Any RX_DV still arriving from the master is ignored.
- States: IDLE, SETUP, SEND, WAIT_RX, READ, HOLD, GAP.
- IDLE:
  - i_Req=1 with i_Len!=0 → latch i_Addr and i_Len, o_Busy=1, CS_n=0, go to SETUP.
  - i_Req=1 with i_Len=0 → o_Done pulses on the next cycle; CS_n stays high; no SPI activity; o_Busy stays 0.
  - i_Req outside IDLE is ignored.
- SETUP: count CS_SETUP_CLKS cycles, then go to SEND.
- SEND:
  - Header sequence is 0x03, A[23:16], A[15:8], A[7:0], indexed by a 3-bit header counter.
  - When i_TX_Ready=1, drive o_TX_DV=1 for exactly one cycle with o_TX_Byte set to the current header byte, then go to WAIT_RX.
- WAIT_RX:
  - On i_RX_DV, discard the byte.
  - If header bytes remain, return to SEND.
  - Otherwise go to READ with a byte counter loaded from the latched length.
- READ:
  - When i_TX_Ready=1 and no byte is outstanding, pulse o_TX_DV with o_TX_Byte=0x00 and mark a byte outstanding.
  - On i_RX_DV: o_Data=i_RX_Byte, o_Data_DV=1 for one cycle, decrement the counter, clear outstanding.
  - Counter reaching 0 → HOLD.
- Byte spacing: never issue a new o_TX_DV while a byte is outstanding. At most one byte is ever in flight. i_TX_Ready alone never licenses a second pulse.
- HOLD: count CS_HOLD_CLKS cycles, then CS_n=1 and o_Done=1 for one cycle; go to GAP.
- GAP: count CS_IDLE_CLKS cycles with CS_n high, then o_Busy=0 and go to IDLE. The next i_Req is accepted on the first IDLE cycle.
- Latency: o_Done follows the final o_Data_DV by CS_HOLD_CLKS+1 cycles.
- i_Len = max (2^LEN_W − 1) is legal. The counter is LEN_W bits wide and never wraps below 0.
- An i_RX_DV arriving when no byte is outstanding (SETUP, HOLD, GAP, IDLE) is ignored.
- Counters are sized $clog2(max(CS_*)+1).

Optional Feature:
- Macro: SPI_FAST_READ_EN.
- Defined: command byte is 0x0B; the header is 5 bytes (cmd, 3 address bytes, one dummy 0x00); the dummy's RX byte is discarded.
- Undefined: command 0x03 with a 4-byte header exactly as above.
- o_Data_DV count equals i_Len in both builds.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum;
  - constants FLASH_CMD_READ=8'h03, FLASH_CMD_FAST_READ=8'h0B, SPI_DUMMY_BYTE=8'h00;
  - header length constants (4/5).
- One sub-module is natural: spi_cs_timer, a loadable down-counter with a done flag. It is reused for SETUP, HOLD and GAP.
- The SPI byte master is instantiated by the parent, not inside this block.

Test Plan:
- Basic read: i_Req, i_Addr=0x012345, i_Len=3, master model returning AA,BB,CC after the header → MOSI bytes 03,01,23,45,00,00,00; o_Data_DV ×3 with AA,BB,CC; one o_Done; CS_n low across all 7 bytes.
- Zero length: i_Len=0 → o_Done one cycle later; CS_n never low; o_TX_DV never pulses.
- Back-to-back: second i_Req held high throughout the first transaction → ignored until IDLE; CS_n high for ≥CS_IDLE_CLKS cycles between transactions.
- Reset mid-READ: i_Rst during byte 2 of 5 → next cycle CS_n=1, o_Busy=0, no further o_Data_DV; a fresh request then completes normally.
- Spurious RX: i_RX_DV injected during SETUP and GAP → no o_Data_DV; byte counts unchanged.
- SPI_FAST_READ_EN build: i_Addr=0x000010, i_Len=1 → MOSI 0B,00,00,10,00,00; exactly one o_Data_DV.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the serial-flash read sequencer: state encoding,
// flash opcodes and header lengths.
package spi_pkg;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_SEND    = 3'd2;
  localparam logic [2:0] ST_WAIT_RX = 3'd3;
  localparam logic [2:0] ST_READ    = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;
  localparam logic [2:0] ST_GAP     = 3'd6;

  localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
  localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] SPI_DUMMY_BYTE      = 8'h00;

  localparam int HDR_LEN_READ = 4;
  localparam int HDR_LEN_FAST = 5;

  function automatic int spi_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_cs_timer.sv
// Loadable down-counter with a terminal-count flag; shared by the
// chip-select setup, hold and idle-gap intervals.
module spi_cs_timer #(
  parameter int W = 4
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Load,
  input  logic [W-1:0] i_Load_Val,
  output logic         o_Done
);

  logic [W-1:0] count;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count <= '0;
    end else if (i_Load) begin
      count <= i_Load_Val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign o_Done = (count == '0);

endmodule

// File: rtl/spi_flash_reader.sv
// Serial-flash READ sequencer in front of an SPI byte master.
// Build option: define SPI_FAST_READ_EN for opcode 0x0B with one dummy byte.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | CS_n high, waiting for i_Req
// SETUP    | CS_n low, CS setup interval before the first byte
// SEND     | offer next header byte (cmd / address / dummy) to master
// WAIT_RX  | header byte in flight; its RX byte is discarded
// READ     | clock dummy 0x00 bytes, forward RX bytes as data
// HOLD     | CS hold interval after the last received byte
// GAP      | CS_n high, minimum idle before the next transaction
module spi_flash_reader
  import spi_pkg::*;
#(
  parameter int LEN_W         = 16,
  parameter int CS_SETUP_CLKS = 8,
  parameter int CS_HOLD_CLKS  = 8,
  parameter int CS_IDLE_CLKS  = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Req,
  input  logic [23:0]      i_Addr,
  input  logic [LEN_W-1:0] i_Len,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [7:0]       o_Data,
  output logic             o_Data_DV,
  output logic [7:0]       o_TX_Byte,
  output logic             o_TX_DV,
  input  logic             i_TX_Ready,
  input  logic             i_RX_DV,
  input  logic [7:0]       i_RX_Byte,
  output logic             o_SPI_CS_n
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE = FLASH_CMD_FAST_READ;
  localparam int         HDR_LEN  = HDR_LEN_FAST;
`else
  localparam logic [7:0] CMD_BYTE = FLASH_CMD_READ;
  localparam int         HDR_LEN  = HDR_LEN_READ;
`endif

  localparam int TMR_W = $clog2(spi_max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS) + 1);

  // SETUP and GAP leave on the Nth cycle; HOLD raises o_Done on the
  // edge after its Nth cycle, giving done = last data + HOLD + 1.
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'((CS_SETUP_CLKS > 0) ? CS_SETUP_CLKS - 1 : 0);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(CS_HOLD_CLKS);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'((CS_IDLE_CLKS > 0) ? CS_IDLE_CLKS - 1 : 0);
  localparam logic [2:0]       HDR_LAST = 3'(HDR_LEN - 1);

  state_t             state;
  logic [23:0]        addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   byte_cnt;
  logic [2:0]         hdr_cnt;
  logic               outstanding;
  logic [7:0]         hdr_byte;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_done;
  logic               data_rx;
  logic               last_rx;

  assign data_rx = (state == ST_READ) && i_RX_DV && outstanding;
  assign last_rx = data_rx && (byte_cnt == LEN_W'(1));

  always_comb begin
    case (hdr_cnt)
      3'd0:    hdr_byte = CMD_BYTE;
      3'd1:    hdr_byte = addr_q[23:16];
      3'd2:    hdr_byte = addr_q[15:8];
      3'd3:    hdr_byte = addr_q[7:0];
      default: hdr_byte = SPI_DUMMY_BYTE;
    endcase
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (i_Req && (i_Len != '0)) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_READ: begin
        if (last_rx) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      default: ;
    endcase
  end

  spi_cs_timer #(.W(TMR_W)) u_cs_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Load     (tmr_load),
    .i_Load_Val (tmr_val),
    .o_Done     (tmr_done)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= ST_IDLE;
      o_SPI_CS_n  <= 1'b1;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
      o_Data_DV   <= 1'b0;
      o_TX_DV     <= 1'b0;
      o_Data      <= 8'h00;
      o_TX_Byte   <= 8'h00;
      addr_q      <= '0;
      len_q       <= '0;
      byte_cnt    <= '0;
      hdr_cnt     <= '0;
      outstanding <= 1'b0;
    end else begin
      o_Done    <= 1'b0;
      o_Data_DV <= 1'b0;
      o_TX_DV   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_Req) begin
            if (i_Len == '0) begin
              o_Done <= 1'b1;
            end else begin
              addr_q     <= i_Addr;
              len_q      <= i_Len;
              hdr_cnt    <= '0;
              o_Busy     <= 1'b1;
              o_SPI_CS_n <= 1'b0;
              state      <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          if (tmr_done) state <= ST_SEND;
        end
        ST_SEND: begin
          if (i_TX_Ready) begin
            o_TX_DV   <= 1'b1;
            o_TX_Byte <= hdr_byte;
            state     <= ST_WAIT_RX;
          end
        end
        ST_WAIT_RX: begin
          if (i_RX_DV) begin
            if (hdr_cnt == HDR_LAST) begin
              byte_cnt    <= len_q;
              outstanding <= 1'b0;
              state       <= ST_READ;
            end else begin
              hdr_cnt <= hdr_cnt + 3'd1;
              state   <= ST_SEND;
            end
          end
        end
        ST_READ: begin
          // RX takes priority so a ready master never sees a second byte in flight
          if (data_rx) begin
            o_Data      <= i_RX_Byte;
            o_Data_DV   <= 1'b1;
            byte_cnt    <= byte_cnt - LEN_W'(1);
            outstanding <= 1'b0;
            if (last_rx) state <= ST_HOLD;
          end else if (i_TX_Ready && !outstanding) begin
            o_TX_DV     <= 1'b1;
            o_TX_Byte   <= SPI_DUMMY_BYTE;
            outstanding <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            o_SPI_CS_n <= 1'b1;
            o_Done     <= 1'b1;
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr_done) begin
            o_Busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader with a simple SPI byte-master model.
module tb_spi_flash_reader;

  localparam int LEN_W  = 16;
  localparam int SETUP  = 8;
  localparam int HOLD   = 8;
  localparam int IDLE_C = 16;

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD   = 8'h0B;
  localparam int         HDR_N = 5;
`else
  localparam logic [7:0] CMD   = 8'h03;
  localparam int         HDR_N = 4;
`endif

  logic             i_Clk;
  logic             i_Rst;
  logic             i_Req;
  logic [23:0]      i_Addr;
  logic [LEN_W-1:0] i_Len;
  logic             o_Busy;
  logic             o_Done;
  logic [7:0]       o_Data;
  logic             o_Data_DV;
  logic [7:0]       o_TX_Byte;
  logic             o_TX_DV;
  logic             i_TX_Ready;
  logic             i_RX_DV;
  logic [7:0]       i_RX_Byte;
  logic             o_SPI_CS_n;

  spi_flash_reader #(
    .LEN_W(LEN_W), .CS_SETUP_CLKS(SETUP), .CS_HOLD_CLKS(HOLD), .CS_IDLE_CLKS(IDLE_C)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Req(i_Req), .i_Addr(i_Addr), .i_Len(i_Len),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Data(o_Data), .o_Data_DV(o_Data_DV),
    .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV), .i_TX_Ready(i_TX_Ready),
    .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte), .o_SPI_CS_n(o_SPI_CS_n)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_data_q[$];
  logic [7:0] miso_q[$];
  int done_q[$];
  int data_seen = 0;
  int done_seen = 0;
  int tx_seen   = 0;
  int cyc = 0;
  int last_data_cyc = 0;
  int spur_req  = 0;
  int spur_done = 0;

  always @(posedge i_Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Master model: one byte at a time, answers 3 cycles after each TX pulse.
  initial begin
    int dly;
    bit busy_m;
    dly = 0;
    busy_m = 0;
    i_TX_Ready = 1'b1;
    i_RX_DV = 1'b0;
    i_RX_Byte = 8'h00;
    forever begin
      @(negedge i_Clk);
      i_RX_DV = 1'b0;
      if (busy_m) begin
        if (dly == 0) begin
          i_RX_DV = 1'b1;
          if (miso_q.size() > 0) i_RX_Byte = miso_q.pop_front();
          else i_RX_Byte = 8'hEE;
          i_TX_Ready = 1'b1;
          busy_m = 0;
        end else begin
          dly--;
        end
      end else if (o_TX_DV) begin
        i_TX_Ready = 1'b0;
        busy_m = 1;
        dly = 2;
      end else if (spur_req != spur_done) begin
        i_RX_DV = 1'b1;
        i_RX_Byte = 8'h77;
        spur_done++;
      end
    end
  end

  // MOSI monitor
  initial begin
    forever begin
      @(negedge i_Clk);
      if (o_TX_DV) begin
        tx_seen++;
        check("tx_cs_low", o_SPI_CS_n, 1'b0);
        if (exp_tx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got 0x%0h expected no byte", o_TX_Byte);
        end else begin
          check("tx_byte", o_TX_Byte, exp_tx_q.pop_front());
        end
      end
    end
  end

  // Data monitor
  initial begin
    forever begin
      @(negedge i_Clk);
      if (o_Data_DV) begin
        data_seen++;
        last_data_cyc = cyc;
        if (exp_data_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL data_unexpected: got 0x%0h expected no byte", o_Data);
        end else begin
          check("data_byte", o_Data, exp_data_q.pop_front());
        end
      end
    end
  end

  // Done monitor
  initial begin
    logic prev_done;
    int lat_chk;
    prev_done = 1'b0;
    forever begin
      @(negedge i_Clk);
      if (o_Done) begin
        done_seen++;
        check("done_single", prev_done, 1'b0);
        check("done_cs_high", o_SPI_CS_n, 1'b1);
        if (done_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: got pulse expected none");
        end else begin
          lat_chk = done_q.pop_front();
          if (lat_chk != 0) check("done_latency", cyc - last_data_cyc, HOLD + 1);
        end
      end
      prev_done = o_Done;
    end
  end

  task automatic push_hdr(input logic [23:0] addr);
    exp_tx_q.push_back(CMD);
    exp_tx_q.push_back(addr[23:16]);
    exp_tx_q.push_back(addr[15:8]);
    exp_tx_q.push_back(addr[7:0]);
    if (HDR_N == 5) exp_tx_q.push_back(8'h00);
    for (int i = 0; i < HDR_N; i++) miso_q.push_back(8'hC0 + 8'(i));
  endtask

  task automatic push_data(input logic [7:0] b);
    exp_tx_q.push_back(8'h00);
    miso_q.push_back(b);
    exp_data_q.push_back(b);
  endtask

  task automatic start_req(input logic [23:0] addr, input logic [LEN_W-1:0] len);
    @(negedge i_Clk);
    i_Addr = addr;
    i_Len = len;
    i_Req = 1'b1;
    @(negedge i_Clk);
    i_Req = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_seen < target && n < 2000) begin
      @(negedge i_Clk);
      n++;
    end
    check(name, (done_seen >= target), 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_Busy && n < 500) begin
      @(negedge i_Clk);
      n++;
    end
    check(name, o_Busy, 1'b0);
    @(negedge i_Clk);
  endtask

  initial begin
    int base;
    int falls;
    int high_run;
    int gap_len;
    logic prev_cs;
    int n;

    i_Rst = 1'b1;
    i_Req = 1'b0;
    i_Addr = '0;
    i_Len = '0;
    repeat (3) @(negedge i_Clk);
    check("rst_cs_n", o_SPI_CS_n, 1'b1);
    check("rst_busy", o_Busy, 1'b0);
    check("rst_done", o_Done, 1'b0);
    check("rst_data_dv", o_Data_DV, 1'b0);
    check("rst_tx_dv", o_TX_DV, 1'b0);
    check("rst_data", o_Data, 8'h00);
    check("rst_tx_byte", o_TX_Byte, 8'h00);
    i_Rst = 1'b0;
    @(negedge i_Clk);

    // Basic read: 03 01 23 45 00 00 00, data AA BB CC
    push_hdr(24'h012345);
    push_data(8'hAA);
    push_data(8'hBB);
    push_data(8'hCC);
    done_q.push_back(1);
    start_req(24'h012345, 16'd3);
    check("basic_busy", o_Busy, 1'b1);
    wait_done(1, "basic_done_timeout");
    check("basic_data_count", data_seen, 3);
    check("basic_tx_count", tx_seen, HDR_N + 3);
    wait_idle("basic_idle_timeout");

    // Zero length: done next cycle, no CS, no SPI traffic
    base = tx_seen;
    done_q.push_back(0);
    @(negedge i_Clk);
    i_Addr = 24'h777777;
    i_Len = 16'd0;
    i_Req = 1'b1;
    @(negedge i_Clk);
    i_Req = 1'b0;
    check("zero_done", o_Done, 1'b1);
    check("zero_busy", o_Busy, 1'b0);
    check("zero_cs", o_SPI_CS_n, 1'b1);
    @(negedge i_Clk);
    check("zero_done_clear", o_Done, 1'b0);
    check("zero_cs_later", o_SPI_CS_n, 1'b1);
    repeat (3) @(negedge i_Clk);
    check("zero_no_tx", tx_seen, base);

    // Spurious RX during SETUP and GAP
    base = data_seen;
    push_hdr(24'h00ABCD);
    push_data(8'h11);
    push_data(8'h22);
    done_q.push_back(1);
    start_req(24'h00ABCD, 16'd2);
    repeat (2) @(negedge i_Clk);
    spur_req++;
    wait_done(3, "spur_done_timeout");
    spur_req++;
    repeat (6) @(negedge i_Clk);
    check("spur_data_count", data_seen - base, 2);
    wait_idle("spur_idle_timeout");

    // Back-to-back with i_Req held high through the first transaction
    base = data_seen;
    push_hdr(24'h100000);
    push_data(8'h31);
    push_data(8'h32);
    done_q.push_back(1);
    push_hdr(24'h200001);
    push_data(8'h41);
    done_q.push_back(1);
    @(negedge i_Clk);
    i_Addr = 24'h100000;
    i_Len = 16'd2;
    i_Req = 1'b1;
    @(negedge i_Clk);
    i_Addr = 24'h200001;
    i_Len = 16'd1;
    prev_cs = o_SPI_CS_n;
    falls = (o_SPI_CS_n == 1'b0) ? 1 : 0;
    high_run = 0;
    gap_len = 0;
    n = 0;
    while (done_seen < 5 && n < 3000) begin
      @(negedge i_Clk);
      n++;
      if (prev_cs && !o_SPI_CS_n) begin
        falls++;
        gap_len = high_run;
        if (falls >= 2) i_Req = 1'b0;
      end
      high_run = o_SPI_CS_n ? high_run + 1 : 0;
      prev_cs = o_SPI_CS_n;
    end
    i_Req = 1'b0;
    check("b2b_done_timeout", (done_seen >= 5), 1'b1);
    check("b2b_two_frames", falls, 2);
    check("b2b_gap_ok", (gap_len >= IDLE_C), 1'b1);
    check("b2b_data_count", data_seen - base, 3);
    wait_idle("b2b_idle_timeout");
    repeat (IDLE_C + 4) @(negedge i_Clk);
    check("b2b_no_third", o_SPI_CS_n, 1'b1);

    // Reset during byte 2 of 5
    base = data_seen;
    push_hdr(24'h0000FF);
    push_data(8'h51);
    push_data(8'h52);
    push_data(8'h53);
    push_data(8'h54);
    push_data(8'h55);
    done_q.push_back(1);
    start_req(24'h0000FF, 16'd5);
    n = 0;
    while (data_seen < base + 1 && n < 1000) begin
      @(negedge i_Clk);
      n++;
    end
    check("rstmid_first_byte", (data_seen >= base + 1), 1'b1);
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    check("rstmid_cs", o_SPI_CS_n, 1'b1);
    check("rstmid_busy", o_Busy, 1'b0);
    check("rstmid_tx_dv", o_TX_DV, 1'b0);
    exp_tx_q.delete();
    exp_data_q.delete();
    done_q.delete();
    i_Rst = 1'b0;
    repeat (12) @(negedge i_Clk);
    check("rstmid_no_more_data", data_seen - base, 1);
    check("rstmid_no_done", done_seen, 5);
    check("rstmid_cs_idle", o_SPI_CS_n, 1'b1);
    miso_q.delete();

    base = data_seen;
    push_hdr(24'h000200);
    push_data(8'h61);
    push_data(8'h62);
    done_q.push_back(1);
    start_req(24'h000200, 16'd2);
    wait_done(6, "fresh_done_timeout");
    check("fresh_data_count", data_seen - base, 2);
    wait_idle("fresh_idle_timeout");

    // Single byte at 0x000010 (fast-read build adds the dummy header byte)
    base = data_seen;
    push_hdr(24'h000010);
    push_data(8'h99);
    done_q.push_back(1);
    start_req(24'h000010, 16'd1);
    wait_done(7, "one_done_timeout");
    check("one_data_count", data_seen - base, 1);
    wait_idle("one_idle_timeout");

    check("end_tx_left", exp_tx_q.size(), 0);
    check("end_data_left", exp_data_q.size(), 0);
    check("end_done_left", done_q.size(), 0);
    check("end_done_total", done_seen, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
